// File: rtl/emon_pkg.sv
// Shared encodings for the event-monitor counter block.
package emon_pkg;

    // Counting behaviour of one channel
    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_UP   = 2'd2,
        MODE_DRL  = 2'd3
    } emon_mode_e;

    // Register field selected by reg_addr[1:0]
    localparam logic [1:0] FLD_CNT = 2'd0;
    localparam logic [1:0] FLD_RLD = 2'd1;
    localparam logic [1:0] FLD_CFG = 2'd2;
    localparam logic [1:0] FLD_STS = 2'd3;

    // Config word layout: irq_en at bit 6, mode at [5:4], sel at [3:0]
    localparam int unsigned CFG_W = 7;
    typedef struct packed {
        logic       irq_en;
        emon_mode_e mode;
        logic [3:0] sel;
    } emon_cfg_t;

    // Single-channel legacy behaviour: count down on event line 0
    localparam emon_cfg_t CFG_RESET = '{irq_en: 1'b0, mode: MODE_DOWN, sel: 4'd0};

    // Sticky status bit positions (also the W1C bit positions)
    localparam int unsigned STS_ZERO = 0;
    localparam int unsigned STS_OVF  = 1;

endpackage

// File: rtl/emon_multi_counter_if.sv
// Register bus and event/status signals of the multi-channel event monitor.
interface emon_multi_counter_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 32,
    parameter int unsigned EW  = 16
);
    localparam int unsigned AW = $clog2(NCH) + 2;

    logic [EW-1:0]     emon_vector;
    logic              freeze;
    logic              reg_write;
    logic [AW-1:0]     reg_addr;
    logic [DW-1:0]     reg_data;
    logic [NCH*DW-1:0] emon_reg;
    logic [NCH-1:0]    emon_zero_flag;
    logic [2*NCH-1:0]  emon_status;
    logic              emon_irq;

    modport master (
        output emon_vector, freeze, reg_write, reg_addr, reg_data,
        input  emon_reg, emon_zero_flag, emon_status, emon_irq
    );

    modport slave (
        input  emon_vector, freeze, reg_write, reg_addr, reg_data,
        output emon_reg, emon_zero_flag, emon_status, emon_irq
    );

endinterface

// File: rtl/emon_channel.sv
// One event counter channel: event select/pipeline, counter, reload, config, sticky status.
module emon_channel
    import emon_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned EW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [EW-1:0] i_ev_vec,
    input  logic          i_freeze,
    input  logic          i_wr_cnt,
    input  logic          i_wr_rld,
    input  logic          i_wr_cfg,
    input  logic          i_wr_sts,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_cnt,
    output logic [1:0]    o_sticky,
    output logic          o_irq_req_c
);

    localparam int unsigned SW = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [DW-1:0] ONES = '1;

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_rld;
    emon_cfg_t     r_cfg;
    logic          r_ev_q;
    logic [1:0]    r_sticky;

    logic [SW-1:0] w_sel;
    logic [DW-1:0] w_cnt_nxt;
    logic          w_set_zero;
    logic          w_set_ovf;
    logic          w_clr_zero;
    logic          w_clr_ovf;

    // Select bits above the event-vector width are ignored
    assign w_sel      = r_cfg.sel[SW-1:0];
    assign w_clr_zero = i_wr_sts & i_wdata[STS_ZERO];
    assign w_clr_ovf  = i_wr_sts & i_wdata[STS_OVF];

    // Next counter value: write wins, then freeze/OFF hold, then the mode action
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_set_zero = 1'b0;
        w_set_ovf  = 1'b0;
        if (i_wr_cnt) begin
            w_cnt_nxt = i_wdata;
        end else if (!i_freeze && r_ev_q) begin
            case (r_cfg.mode)
                MODE_DOWN: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt  = r_cnt - DW'(1);
                        w_set_zero = (r_cnt == DW'(1));
                    end
                end
                MODE_UP: begin
                    if (r_cnt == ONES) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end
                end
                MODE_DRL: begin
                    if (r_cnt == '0) begin
                        w_cnt_nxt = r_rld;
                    end else begin
                        w_cnt_nxt  = r_cnt - DW'(1);
                        w_set_zero = (r_cnt == DW'(1));
                    end
                end
                default: begin
                    w_cnt_nxt = r_cnt;
                end
            endcase
        end
    end

    // Channel state; a set coinciding with a W1C clear leaves the sticky bit set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= ONES;
            r_rld    <= ONES;
            r_cfg    <= CFG_RESET;
            r_ev_q   <= 1'b0;
            r_sticky <= 2'b00;
        end else begin
            r_ev_q <= i_ev_vec[w_sel];
            r_cnt  <= w_cnt_nxt;
            if (i_wr_rld) begin
                r_rld <= i_wdata;
            end
            if (i_wr_cfg) begin
                r_cfg <= emon_cfg_t'(i_wdata[CFG_W-1:0]);
            end
            r_sticky[STS_ZERO] <= (r_sticky[STS_ZERO] & ~w_clr_zero) | w_set_zero;
            r_sticky[STS_OVF]  <= (r_sticky[STS_OVF]  & ~w_clr_ovf)  | w_set_ovf;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_sticky    = r_sticky;
    assign o_irq_req_c = r_cfg.irq_en & (|r_sticky);

endmodule

// File: rtl/emon_multi_counter.sv
// Multi-channel event monitor: register address decode, NCH counter channels, interrupt OR.
module emon_multi_counter
    import emon_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 32,
    parameter int unsigned EW  = 16,
    localparam int unsigned AW = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EW-1:0]     emon_vector,
    input  logic              freeze,
    input  logic              reg_write,
    input  logic [AW-1:0]     reg_addr,
    input  logic [DW-1:0]     reg_data,
    output logic [NCH*DW-1:0] emon_reg,
    output logic [NCH-1:0]    emon_zero_flag,
    output logic [2*NCH-1:0]  emon_status,
    output logic              emon_irq
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]     w_fld;
    logic [CHW-1:0] w_ch;
    logic [DW-1:0]  w_cnt    [NCH];
    logic [1:0]     w_sticky [NCH];
    logic [NCH-1:0] w_irq_req;
    logic           r_irq;

    assign w_fld = reg_addr[1:0];

    // Channel index field; absent when there is a single channel
    if (NCH > 1) begin : g_ch_idx
        assign w_ch = reg_addr[AW-1:2];
    end else begin : g_ch_one
        assign w_ch = '0;
    end

    // Channels whose index is not instantiated never see a write strobe
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic w_hit;
        assign w_hit = reg_write && (w_ch == CHW'(i));

        emon_channel #(
            .DW (DW),
            .EW (EW)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .i_ev_vec    (emon_vector),
            .i_freeze    (freeze),
            .i_wr_cnt    (w_hit && (w_fld == FLD_CNT)),
            .i_wr_rld    (w_hit && (w_fld == FLD_RLD)),
            .i_wr_cfg    (w_hit && (w_fld == FLD_CFG)),
            .i_wr_sts    (w_hit && (w_fld == FLD_STS)),
            .i_wdata     (reg_data),
            .o_cnt       (w_cnt[i]),
            .o_sticky    (w_sticky[i]),
            .o_irq_req_c (w_irq_req[i])
        );

        assign emon_reg[i*DW +: DW]  = w_cnt[i];
        assign emon_zero_flag[i]     = ~|w_cnt[i];
        assign emon_status[2*i +: 2] = w_sticky[i];
    end

    // Interrupt follows the sticky bits by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_irq_req;
        end
    end

    assign emon_irq = r_irq;

endmodule
